// File: rtl/mmu_paged.sv
// Paged MMU: NUM_MPR page registers map a VADDR_W virtual address onto a PA_W physical address,
// with a TAM/TMA register load/store handshake, ST0/1/2 override and chip-enable decode.
module mmu_paged #(
  parameter int NUM_MPR = 8,
  parameter int VADDR_W = 16,
  parameter int MPR_W   = 8,
  parameter logic [MPR_W-1:0] MPR_RST = '0,
  parameter logic [MPR_W+VADDR_W-$clog2(NUM_MPR)-1:0] VDC_BASE = 21'h1FE000
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         rdy,
  input  logic                                         load_en,
  input  logic                                         store_en,
  input  logic [NUM_MPR-1:0]                           mpr_mask,
  input  logic [MPR_W-1:0]                             d_in,
  input  logic [VADDR_W-1:0]                           vaddr,
  input  logic [2:0]                                   stx_override,
  output logic [MPR_W+VADDR_W-$clog2(NUM_MPR)-1:0]     paddr,
  output logic [MPR_W-1:0]                             d_out,
  output logic                                         busy,
  output logic [7:0]                                   ce_n
);

  localparam int PG_W  = $clog2(NUM_MPR);
  localparam int OFF_W = VADDR_W - PG_W;
  localparam int PA_W  = MPR_W + OFF_W;

  // Chip-enable windows are anchored to the top of the physical space so they scale with PA_W.
  localparam logic [PA_W-1:0] PA_TOP  = '1;
  localparam logic [PA_W-1:0] CE_HI   = PA_W'(13'h1FFF);
  localparam logic [PA_W-1:0] CER_LO  = PA_TOP - PA_W'(17'hFFFF);
  localparam logic [PA_W-1:0] CER_HI  = PA_TOP - PA_W'(16'hE000);
  localparam logic [PA_W-1:0] WIN_LO  = PA_TOP - PA_W'(13'h1FFF);
  localparam logic [PA_W-1:0] WIN_SPAN = PA_W'(14'h1800);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_e;

  state_e             state_q, state_d;
  logic [MPR_W-1:0]   mpr_q [NUM_MPR];
  logic [MPR_W-1:0]   mpr_d [NUM_MPR];
  logic [MPR_W-1:0]   databuf_q, databuf_d;
  logic [NUM_MPR-1:0] localmask_q, localmask_d;

  logic [PG_W-1:0]    sel_idx;
  logic               sel_found;
  logic [PG_W-1:0]    page_idx;
  logic [PA_W-1:0]    win_off;
  logic [2:0]         ce_sel;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MPR; i++) begin
        mpr_q[i] <= MPR_RST;
      end
      databuf_q   <= '0;
      localmask_q <= '0;
    end else if (rdy) begin
      mpr_q       <= mpr_d;
      databuf_q   <= databuf_d;
      localmask_q <= localmask_d;
    end
  end

  // Next-state logic; a simultaneous load/store request resolves to load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d = S_LOAD;
        end else if (store_en) begin
          state_d = S_STORE;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      S_STORE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Requests are only sampled in IDLE, so anything arriving while busy is dropped.
  always_comb begin
    databuf_d   = databuf_q;
    localmask_d = localmask_q;
    mpr_d       = mpr_q;
    if (state_q == S_IDLE) begin
      if (load_en) begin
        localmask_d = mpr_mask;
        if (|mpr_mask) begin
          databuf_d = d_in;
        end
      end else if (store_en) begin
        localmask_d = mpr_mask;
      end
    end
    if (state_q == S_LOAD) begin
      for (int i = 0; i < NUM_MPR; i++) begin
        if (localmask_q[i]) begin
          mpr_d[i] = databuf_q;
        end
      end
    end
  end

  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NUM_MPR; i++) begin
      if (localmask_q[i] && !sel_found) begin
        sel_idx   = PG_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    busy  = (state_q != S_IDLE);
    d_out = databuf_q;
    if (state_q == S_STORE && sel_found) begin
      d_out = mpr_q[sel_idx];
    end
  end

  // Offset is a pure bit-slice: addresses never carry across a page boundary.
  always_comb begin
    page_idx = vaddr[VADDR_W-1 -: PG_W];
    if (stx_override[0]) begin
      paddr = VDC_BASE;
    end else if (stx_override[1]) begin
      paddr = VDC_BASE + PA_W'(2);
    end else if (stx_override[2]) begin
      paddr = VDC_BASE + PA_W'(3);
    end else begin
      paddr = {mpr_q[page_idx], vaddr[OFF_W-1:0]};
    end
  end

  // Six consecutive 1 KiB windows from WIN_LO drive ce_n[2..7].
  always_comb begin
    ce_n    = '1;
    win_off = paddr - WIN_LO;
    ce_sel  = 3'(win_off[12:10]) + 3'd2;
    if (paddr <= CE_HI) begin
      ce_n[0] = 1'b0;
    end else if (paddr >= CER_LO && paddr <= CER_HI) begin
      ce_n[1] = 1'b0;
    end else if (paddr >= WIN_LO && win_off < WIN_SPAN) begin
      ce_n[ce_sel] = 1'b0;
    end
  end

endmodule

// File: tb/tb_mmu_paged.sv
// Bench for mmu_paged: scoreboard of expected outputs plus a decode vector table and
// hand-written load/store/stall/reset sequences.
module tb_mmu_paged;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rdy;
  logic        load_en;
  logic        store_en;
  logic [7:0]  mpr_mask;
  logic [7:0]  d_in;
  logic [15:0] vaddr;
  logic [2:0]  stx_override;
  logic [20:0] paddr;
  logic [7:0]  d_out;
  logic        busy;
  logic [7:0]  ce_n;

  int total = 0;
  int bad   = 0;

  mmu_paged dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rdy          (rdy),
    .load_en      (load_en),
    .store_en     (store_en),
    .mpr_mask     (mpr_mask),
    .d_in         (d_in),
    .vaddr        (vaddr),
    .stx_override (stx_override),
    .paddr        (paddr),
    .d_out        (d_out),
    .busy         (busy),
    .ce_n         (ce_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [15:0] va;
    logic [2:0]  stx;
    logic [20:0] pa;
    logic [7:0]  ce;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[16];

  localparam int O_PADDR = 0;
  localparam int O_CE    = 1;
  localparam int O_DOUT  = 2;
  localparam int O_BUSY  = 3;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      O_PADDR: return 32'(paddr);
      O_CE:    return 32'(ce_n);
      O_DOUT:  return 32'(d_out);
      default: return 32'(busy);
    endcase
  endfunction

  task automatic expect_out(string nm, int sel, logic [31:0] e);
    sb_t s;
    s.nm  = nm;
    s.sel = sel;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    logic [31:0] got;
    #1;
    while (sb_q.size() > 0) begin
      s   = sb_q.pop_front();
      got = observe(s.sel);
      total++;
      if (got !== s.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", s.nm, got, s.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'h0000, 3'b000, 21'h000000, 8'hFE};
    vecs[1]  = '{16'h1FFF, 3'b000, 21'h001FFF, 8'hFE};
    vecs[2]  = '{16'h2000, 3'b000, 21'h1F0000, 8'hFD};
    vecs[3]  = '{16'h5FFF, 3'b000, 21'h1F1FFF, 8'hFD};
    vecs[4]  = '{16'h6000, 3'b000, 21'h000000, 8'hFE};
    vecs[5]  = '{16'hE3FF, 3'b000, 21'h1FE3FF, 8'hFB};
    vecs[6]  = '{16'hE400, 3'b000, 21'h1FE400, 8'hF7};
    vecs[7]  = '{16'hE800, 3'b000, 21'h1FE800, 8'hEF};
    vecs[8]  = '{16'hEC00, 3'b000, 21'h1FEC00, 8'hDF};
    vecs[9]  = '{16'hF000, 3'b000, 21'h1FF000, 8'hBF};
    vecs[10] = '{16'hF7FF, 3'b000, 21'h1FF7FF, 8'h7F};
    vecs[11] = '{16'hF800, 3'b000, 21'h1FF800, 8'hFF};
    vecs[12] = '{16'h1234, 3'b001, 21'h1FE000, 8'hFB};
    vecs[13] = '{16'h1234, 3'b110, 21'h1FE002, 8'hFB};
    vecs[14] = '{16'h1234, 3'b100, 21'h1FE003, 8'hFB};
    vecs[15] = '{16'hE123, 3'b111, 21'h1FE000, 8'hFB};

    reset_n = 1'b0; rdy = 1'b1; load_en = 1'b0; store_en = 1'b0;
    mpr_mask = '0; d_in = '0; vaddr = 16'hE123; stx_override = '0;
    #12;
    expect_out("rst_busy", O_BUSY, 0);
    expect_out("rst_dout", O_DOUT, 0);
    expect_out("rst_paddr", O_PADDR, 32'h000123);
    expect_out("rst_ce", O_CE, 32'hFE);
    drain();
    reset_n = 1'b1;
    tick();

    // TAM into MPR7
    mpr_mask = 8'h80; d_in = 8'hFF; load_en = 1'b1; vaddr = 16'hE000;
    tick();
    load_en = 1'b0; mpr_mask = '0;
    expect_out("tam_busy", O_BUSY, 1);
    expect_out("tam_paddr_old", O_PADDR, 32'h000000);
    drain();
    tick();
    expect_out("tam_idle", O_BUSY, 0);
    expect_out("tam_paddr_new", O_PADDR, 32'h1FE000);
    expect_out("tam_ce7", O_CE, 32'hFB);
    drain();

    // Multi-bit mask load, then TMA reads back the lowest selected MPR
    mpr_mask = 8'h06; d_in = 8'hF8; load_en = 1'b1;
    tick();
    load_en = 1'b0; mpr_mask = '0;
    tick();
    mpr_mask = 8'h06; store_en = 1'b1;
    tick();
    store_en = 1'b0; mpr_mask = '0;
    expect_out("tma06_busy", O_BUSY, 1);
    expect_out("tma06_dout", O_DOUT, 32'hF8);
    drain();
    tick();
    expect_out("tma_done_busy", O_BUSY, 0);
    expect_out("idle_dout_databuf", O_DOUT, 32'hF8);
    drain();
    mpr_mask = 8'h84; store_en = 1'b1;
    tick();
    store_en = 1'b0; mpr_mask = '0;
    expect_out("tma84_lowest", O_DOUT, 32'hF8);
    drain();
    tick();
    mpr_mask = 8'h80; store_en = 1'b1;
    tick();
    store_en = 1'b0; mpr_mask = '0;
    expect_out("tma80_dout", O_DOUT, 32'hFF);
    drain();
    tick();

    // Decode table: MPR1=MPR2=F8, MPR7=FF, others 0
    for (int i = 0; i < 16; i++) begin
      vaddr = vecs[i].va;
      stx_override = vecs[i].stx;
      expect_out($sformatf("vec%0d_paddr", i), O_PADDR, 32'(vecs[i].pa));
      expect_out($sformatf("vec%0d_ce", i), O_CE, 32'(vecs[i].ce));
      drain();
    end
    stx_override = '0;

    // Stall during LOAD
    vaddr = 16'h6000; mpr_mask = 8'h08; d_in = 8'h5A; load_en = 1'b1;
    tick();
    load_en = 1'b0; mpr_mask = '0; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out($sformatf("stall%0d_busy", i), O_BUSY, 1);
      expect_out($sformatf("stall%0d_paddr", i), O_PADDR, 32'h000000);
      drain();
    end
    rdy = 1'b1;
    tick();
    expect_out("stall_done_busy", O_BUSY, 0);
    expect_out("stall_done_paddr", O_PADDR, 32'h0B4000);
    drain();

    // Conflict with zero mask: load wins, nothing written, databuf kept
    load_en = 1'b1; store_en = 1'b1; mpr_mask = 8'h00; d_in = 8'h33;
    tick();
    load_en = 1'b0; store_en = 1'b0;
    expect_out("zero_busy", O_BUSY, 1);
    expect_out("zero_dout", O_DOUT, 32'h5A);
    drain();
    tick();
    expect_out("zero_idle", O_BUSY, 0);
    expect_out("zero_dout_after", O_DOUT, 32'h5A);
    expect_out("zero_paddr", O_PADDR, 32'h0B4000);
    drain();

    // Conflict with real mask: load must win; a request while busy is dropped
    vaddr = 16'h0000; load_en = 1'b1; store_en = 1'b1; mpr_mask = 8'h01; d_in = 8'h11;
    tick();
    store_en = 1'b0; mpr_mask = 8'h02; d_in = 8'h77;
    tick();
    load_en = 1'b0; mpr_mask = '0;
    expect_out("conf_busy", O_BUSY, 0);
    expect_out("conf_paddr", O_PADDR, 32'h022000);
    expect_out("conf_dout", O_DOUT, 32'h11);
    drain();
    vaddr = 16'h2000;
    expect_out("ignored_req_paddr", O_PADDR, 32'h1F0000);
    drain();

    // Asynchronous reset in the middle of a LOAD
    vaddr = 16'hE123; mpr_mask = 8'hFF; d_in = 8'hAA; load_en = 1'b1;
    tick();
    load_en = 1'b0; mpr_mask = '0;
    #2 reset_n = 1'b0;
    expect_out("mrst_busy", O_BUSY, 0);
    expect_out("mrst_dout", O_DOUT, 0);
    expect_out("mrst_paddr", O_PADDR, 32'h000123);
    expect_out("mrst_ce", O_CE, 32'hFE);
    drain();
    tick();
    reset_n = 1'b1;
    tick();
    expect_out("mrst_after_busy", O_BUSY, 0);
    expect_out("mrst_after_paddr", O_PADDR, 32'h000123);
    drain();
    vaddr = 16'h2000;
    expect_out("mrst_mpr1_reset", O_PADDR, 32'h000000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
